// File: rtl/prototype_readout_control_if.sv
// ---------------------------------------------------------------------------
// prototype_readout_control_if
//   Bundles the memory read ports and the outgoing word stream used by
//   prototype_readout_control.
//   master : the readout controller (drives enables/addresses and the stream)
//   slave  : the environment (memories return row data, sink drives out_ready)
//   Signals:
//     weight_mem_en/addr, weight_rdata : weight memory read port
//     bias_mem_en/addr, bias_rdata     : bias memory read port
//     out_valid/out_ready              : stream handshake
//     out_data/out_is_bias/out_way/out_last : stream payload
// ---------------------------------------------------------------------------
interface prototype_readout_control_if #(
  parameter int WAYS_BIT_WIDTH       = 8,
  parameter int WEIGHT_ADDRESS_WIDTH = 8,
  parameter int BIAS_ADDRESS_WIDTH   = 4,
  parameter int PE_COLS              = 16,
  parameter int WEIGHT_WIDTH         = 4,
  parameter int BIAS_WIDTH           = 16
);
  logic                              weight_mem_en;
  logic [WEIGHT_ADDRESS_WIDTH-1:0]   weight_mem_addr;
  logic [PE_COLS*WEIGHT_WIDTH-1:0]   weight_rdata;
  logic                              bias_mem_en;
  logic [BIAS_ADDRESS_WIDTH-1:0]     bias_mem_addr;
  logic [PE_COLS*BIAS_WIDTH-1:0]     bias_rdata;
  logic                              out_valid;
  logic                              out_ready;
  logic [BIAS_WIDTH-1:0]             out_data;
  logic                              out_is_bias;
  logic [WAYS_BIT_WIDTH-1:0]         out_way;
  logic                              out_last;

  modport master (
    output weight_mem_en, weight_mem_addr, input weight_rdata,
    output bias_mem_en, bias_mem_addr, input bias_rdata,
    output out_valid, input out_ready,
    output out_data, out_is_bias, out_way, out_last
  );

  modport slave (
    input weight_mem_en, weight_mem_addr, output weight_rdata,
    input bias_mem_en, bias_mem_addr, output bias_rdata,
    input out_valid, output out_ready,
    input out_data, out_is_bias, out_way, out_last
  );
endinterface

// File: rtl/prototype_readout_control.sv
// ---------------------------------------------------------------------------
// prototype_readout_control
//   Streams the learned prototypes (weight rows, then bias) out of the weight
//   and bias memories one word at a time, way by way, for host readback.
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     start, abort          : begin / cancel a readout
//     core_idle             : start is honoured only while the core is idle
//     ways_received, embedding_layer_blocks, max_weight_address,
//     max_bias_address, use_subsection : readout configuration (latched at start)
//     bus                   : memory read ports and output stream (master side)
//     busy, done            : status; done pulses one cycle at completion
// ---------------------------------------------------------------------------
module prototype_readout_control #(
  parameter int WAYS_BIT_WIDTH       = 8,
  parameter int BLOCKS_WIDTH         = 4,
  parameter int WEIGHT_ADDRESS_WIDTH = 8,
  parameter int BIAS_ADDRESS_WIDTH   = 4,
  parameter int PE_COLS              = 16,
  parameter int SUBSECTION_SIZE      = 4,
  parameter int WEIGHT_WIDTH         = 4,
  parameter int BIAS_WIDTH           = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            core_idle,
  input  logic [WAYS_BIT_WIDTH-1:0]       ways_received,
  input  logic [BLOCKS_WIDTH-1:0]         embedding_layer_blocks,
  input  logic [WEIGHT_ADDRESS_WIDTH-1:0] max_weight_address,
  input  logic [BIAS_ADDRESS_WIDTH-1:0]   max_bias_address,
  input  logic                            use_subsection,
  prototype_readout_control_if.master     bus,
  output logic                            busy,
  output logic                            done
);
  localparam int PE_LOG  = $clog2(PE_COLS);
  localparam int SUB_LOG = $clog2(SUBSECTION_SIZE);
  localparam int LANE_W  = (PE_LOG > 0) ? PE_LOG : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Row group holding a way: the way index with the lane bits stripped.
  function automatic logic [WAYS_BIT_WIDTH-1:0] group_f(input logic [WAYS_BIT_WIDTH-1:0] way,
                                                        input logic subsec);
    if (subsec) group_f = way >> SUB_LOG;
    else        group_f = way >> PE_LOG;
  endfunction

  // Lane within the row: the low bits of the way index.
  function automatic logic [LANE_W-1:0] lane_f(input logic [WAYS_BIT_WIDTH-1:0] way,
                                               input logic subsec);
    logic [WAYS_BIT_WIDTH-1:0] full;
    if (subsec) full = way & WAYS_BIT_WIDTH'(SUBSECTION_SIZE - 1);
    else        full = way & WAYS_BIT_WIDTH'(PE_COLS - 1);
    lane_f = full[LANE_W-1:0];
  endfunction

  // Weight address; all arithmetic wraps in the address width.
  function automatic logic [WEIGHT_ADDRESS_WIDTH-1:0] weight_addr_f(
      input logic [WEIGHT_ADDRESS_WIDTH-1:0] base, input logic [WAYS_BIT_WIDTH-1:0] grp,
      input logic [BLOCKS_WIDTH-1:0] blocks, input logic [BLOCKS_WIDTH-1:0] blk);
    logic [BLOCKS_WIDTH:0] stride;
    stride = {1'b0, blocks} + {{BLOCKS_WIDTH{1'b0}}, 1'b1};
    weight_addr_f = base + WEIGHT_ADDRESS_WIDTH'(grp) * WEIGHT_ADDRESS_WIDTH'(stride)
                  + WEIGHT_ADDRESS_WIDTH'(blk);
  endfunction

  function automatic logic [BIAS_WIDTH-1:0] sext_f(input logic [WEIGHT_WIDTH-1:0] w);
    sext_f = {{(BIAS_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
  endfunction

  state_t                          state_q, state_d;
  logic [WAYS_BIT_WIDTH-1:0]       way_q, way_d;
  logic [BLOCKS_WIDTH-1:0]         blk_q, blk_d;
  logic                            bias_q, bias_d;      // current word is the bias
  logic [WAYS_BIT_WIDTH-1:0]       ways_q, ways_d;
  logic [BLOCKS_WIDTH-1:0]         blocks_q, blocks_d;
  logic [WEIGHT_ADDRESS_WIDTH-1:0] wbase_q, wbase_d;
  logic [BIAS_ADDRESS_WIDTH-1:0]   bbase_q, bbase_d;
  logic                            subsec_q, subsec_d;
  logic                            wen_q, wen_d;
  logic [WEIGHT_ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic                            ben_q, ben_d;
  logic [BIAS_ADDRESS_WIDTH-1:0]   baddr_q, baddr_d;
  logic                            valid_q, valid_d;
  logic [BIAS_WIDTH-1:0]           data_q, data_d;
  logic                            is_bias_q, is_bias_d;
  logic [WAYS_BIT_WIDTH-1:0]       oway_q, oway_d;
  logic                            last_q, last_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            issue_s;
  logic [LANE_W-1:0]               lane_s;
  logic                            final_way_s;

  // Next-state, counters, memory requests and stream outputs.
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    blk_d     = blk_q;
    bias_d    = bias_q;
    ways_d    = ways_q;
    blocks_d  = blocks_q;
    wbase_d   = wbase_q;
    bbase_d   = bbase_q;
    subsec_d  = subsec_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    ben_d     = 1'b0;
    baddr_d   = baddr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    is_bias_d = is_bias_q;
    oway_d    = oway_q;
    last_d    = last_q;
    issue_s   = 1'b0;
    lane_s    = lane_f(way_q, subsec_q);
    final_way_s = (way_q == (ways_q - WAYS_BIT_WIDTH'(1'b1)));

    case (state_q)
      S_IDLE: begin
        if (start && core_idle) begin
          ways_d   = ways_received;
          blocks_d = embedding_layer_blocks;
          wbase_d  = max_weight_address;
          bbase_d  = max_bias_address;
          subsec_d = use_subsection;
          way_d    = {WAYS_BIT_WIDTH{1'b0}};
          blk_d    = {BLOCKS_WIDTH{1'b0}};
          bias_d   = 1'b0;
          if (ways_received == {WAYS_BIT_WIDTH{1'b0}}) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_ISSUE;
            issue_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Row data for the request issued last cycle is on rdata now.
        if (bias_q) data_d = bus.bias_rdata[lane_s*BIAS_WIDTH +: BIAS_WIDTH];
        else        data_d = sext_f(bus.weight_rdata[lane_s*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        valid_d   = 1'b1;
        is_bias_d = bias_q;
        oway_d    = way_q;
        last_d    = bias_q && final_way_s;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (!bias_q) begin
            if (blk_q == blocks_q) bias_d = 1'b1;
            else                   blk_d  = blk_q + BLOCKS_WIDTH'(1'b1);
            state_d = S_ISSUE;
            issue_s = 1'b1;
          end else if (final_way_s) begin
            state_d = S_FINISH;
          end else begin
            way_d   = way_q + WAYS_BIT_WIDTH'(1'b1);
            blk_d   = {BLOCKS_WIDTH{1'b0}};
            bias_d  = 1'b0;
            state_d = S_ISSUE;
            issue_s = 1'b1;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle handshake.
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      issue_s = 1'b0;
    end else begin
      issue_s = issue_s;
    end

    // Request uses the already-updated way/block and config.
    if (issue_s) begin
      if (bias_d) begin
        ben_d   = 1'b1;
        baddr_d = bbase_d + BIAS_ADDRESS_WIDTH'(group_f(way_d, subsec_d));
      end else begin
        wen_d   = 1'b1;
        waddr_d = weight_addr_f(wbase_d, group_f(way_d, subsec_d), blocks_d, blk_d);
      end
    end else begin
      wen_d = 1'b0;
      ben_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      way_q     <= {WAYS_BIT_WIDTH{1'b0}};
      blk_q     <= {BLOCKS_WIDTH{1'b0}};
      bias_q    <= 1'b0;
      ways_q    <= {WAYS_BIT_WIDTH{1'b0}};
      blocks_q  <= {BLOCKS_WIDTH{1'b0}};
      wbase_q   <= {WEIGHT_ADDRESS_WIDTH{1'b0}};
      bbase_q   <= {BIAS_ADDRESS_WIDTH{1'b0}};
      subsec_q  <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= {WEIGHT_ADDRESS_WIDTH{1'b0}};
      ben_q     <= 1'b0;
      baddr_q   <= {BIAS_ADDRESS_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      data_q    <= {BIAS_WIDTH{1'b0}};
      is_bias_q <= 1'b0;
      oway_q    <= {WAYS_BIT_WIDTH{1'b0}};
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      way_q     <= way_d;
      blk_q     <= blk_d;
      bias_q    <= bias_d;
      ways_q    <= ways_d;
      blocks_q  <= blocks_d;
      wbase_q   <= wbase_d;
      bbase_q   <= bbase_d;
      subsec_q  <= subsec_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      ben_q     <= ben_d;
      baddr_q   <= baddr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      is_bias_q <= is_bias_d;
      oway_q    <= oway_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.weight_mem_en   = wen_q;
  assign bus.weight_mem_addr = waddr_q;
  assign bus.bias_mem_en     = ben_q;
  assign bus.bias_mem_addr   = baddr_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_data        = data_q;
  assign bus.out_is_bias     = is_bias_q;
  assign bus.out_way         = oway_q;
  assign bus.out_last        = last_q;
  assign busy                = busy_q;
  assign done                = done_q;
endmodule

// File: tb/tb_prototype_readout_control.sv
module tb_prototype_readout_control;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       core_idle;
  logic [7:0] ways_received;
  logic [3:0] embedding_layer_blocks;
  logic [7:0] max_weight_address;
  logic [3:0] max_bias_address;
  logic       use_subsection;
  logic       busy;
  logic       done;

  prototype_readout_control_if #(
    .WAYS_BIT_WIDTH(8), .WEIGHT_ADDRESS_WIDTH(8), .BIAS_ADDRESS_WIDTH(4),
    .PE_COLS(16), .WEIGHT_WIDTH(4), .BIAS_WIDTH(16)
  ) bus_if ();

  prototype_readout_control #(
    .WAYS_BIT_WIDTH(8), .BLOCKS_WIDTH(4), .WEIGHT_ADDRESS_WIDTH(8), .BIAS_ADDRESS_WIDTH(4),
    .PE_COLS(16), .SUBSECTION_SIZE(4), .WEIGHT_WIDTH(4), .BIAS_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .core_idle(core_idle),
    .ways_received(ways_received), .embedding_layer_blocks(embedding_layer_blocks),
    .max_weight_address(max_weight_address), .max_bias_address(max_bias_address),
    .use_subsection(use_subsection), .bus(bus_if), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents and one-cycle read latency model.
  logic [63:0]  wmem [256];
  logic [255:0] bmem [16];
  always @(posedge clk) begin
    if (bus_if.weight_mem_en) bus_if.weight_rdata <= wmem[bus_if.weight_mem_addr];
    if (bus_if.bias_mem_en)   bus_if.bias_rdata   <= bmem[bus_if.bias_mem_addr];
  end

  typedef struct { int addr; bit is_bias; } req_t;
  typedef struct { int data; bit is_bias; int way; bit last; } word_t;
  req_t  exp_req[$];
  word_t exp_word[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: word/request sequence straight from the address-map rules.
  function automatic void build_expect(int ways, int blocks, int wb, int bb, bit sub);
    int lanes, grp, ln, a, wv;
    logic [63:0]  row;
    logic [255:0] brow;
    lanes = sub ? 4 : 16;
    for (int w = 0; w < ways; w++) begin
      grp = w / lanes;
      ln  = w % lanes;
      for (int b = 0; b <= blocks; b++) begin
        a   = (wb + grp * (blocks + 1) + b) % 256;
        row = wmem[a];
        wv  = int'((row >> (ln * 4)) & 64'hF);
        exp_req.push_back('{addr: a, is_bias: 1'b0});
        exp_word.push_back('{data: (wv >= 8) ? wv + 65536 - 16 : wv, is_bias: 1'b0, way: w, last: 1'b0});
      end
      a    = (bb + grp) % 16;
      brow = bmem[a];
      exp_req.push_back('{addr: a, is_bias: 1'b1});
      exp_word.push_back('{data: int'((brow >> (ln * 16)) & 256'hFFFF), is_bias: 1'b1, way: w,
                           last: (w == ways - 1)});
    end
  endfunction

  // Monitor state
  int         cyc = 0;
  bit         done_due = 1'b0;
  bit         en_due = 1'b0;
  bit         prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [7:0]  prev_way;
  int         last_hs = 0;
  bit         first_hs = 1'b1;
  bit         cadence_chk = 1'b0;
  int         done_cnt = 0;
  int         issued_cnt = 0;
  bit         first_cap = 1'b0;
  logic [15:0] first_data = 16'h0;
  bit         rdy_rand = 1'b0;

  // Sample everything on the falling edge, away from the active edge.
  always @(negedge clk) begin
    req_t  r;
    word_t w;
    if (rst_n) begin
      cyc++;
      check_value("done", 64'(done), 64'(done_due));
      if (done) done_cnt++;
      done_due = 1'b0;
      if (en_due) check_value("en_after_start", 64'(bus_if.weight_mem_en), 64'd1);
      en_due = 1'b0;
      if (start && core_idle && !busy && !abort) begin
        if (ways_received == 8'd0) done_due = 1'b1;
        else                       en_due   = 1'b1;
      end
      if (bus_if.weight_mem_en || bus_if.bias_mem_en) begin
        issued_cnt++;
        if (exp_req.size() == 0) begin
          check_value("unexpected_req", 64'({bus_if.bias_mem_en, bus_if.weight_mem_en}), 64'd0);
        end else begin
          r = exp_req.pop_front();
          check_value("req_kind", 64'({bus_if.bias_mem_en, bus_if.weight_mem_en}),
                      r.is_bias ? 64'd2 : 64'd1);
          check_value("req_addr", r.is_bias ? 64'(bus_if.bias_mem_addr) : 64'(bus_if.weight_mem_addr),
                      64'(r.addr));
        end
      end
      if (prev_stall) begin
        check_value("stall_valid", 64'(bus_if.out_valid), 64'd1);
        check_value("stall_data", 64'(bus_if.out_data), 64'(prev_data));
        check_value("stall_way", 64'(bus_if.out_way), 64'(prev_way));
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
      prev_way   = bus_if.out_way;
      if (bus_if.out_valid) begin
        if (exp_word.size() == 0) begin
          check_value("unexpected_valid", 64'(bus_if.out_valid), 64'd0);
        end else if (bus_if.out_ready) begin
          w = exp_word.pop_front();
          check_value("word_data", 64'(bus_if.out_data), 64'(w.data));
          check_value("word_is_bias", 64'(bus_if.out_is_bias), 64'(w.is_bias));
          check_value("word_way", 64'(bus_if.out_way), 64'(w.way));
          check_value("word_last", 64'(bus_if.out_last), 64'(w.last));
          if (first_cap) begin
            first_data = bus_if.out_data;
            first_cap  = 1'b0;
          end
          if (cadence_chk && !first_hs) check_value("cadence", 64'(cyc - last_hs), 64'd3);
          first_hs = 1'b0;
          last_hs  = cyc;
          if (w.last) done_due = 1'b1;
        end
      end
    end
  end

  // Sink ready: random or held high.
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic scramble_cfg();
    ways_received          = 8'($urandom);
    embedding_layer_blocks = 4'($urandom);
    max_weight_address     = 8'($urandom);
    max_bias_address       = 4'($urandom);
    use_subsection         = 1'($urandom);
  endtask

  task automatic do_readout(int ways, int blocks, int wb, int bb, bit sub, bit rnd, bit restart);
    int n, d0, budget;
    build_expect(ways, blocks, wb, bb, sub);
    rdy_rand    = rnd;
    cadence_chk = !rnd;
    first_hs    = 1'b1;
    d0          = done_cnt;
    budget      = ways * (blocks + 2) * 20 + 20;
    @(posedge clk); #1;
    ways_received          = 8'(ways);
    embedding_layer_blocks = 4'(blocks);
    max_weight_address     = 8'(wb);
    max_bias_address       = 4'(bb);
    use_subsection         = sub;
    core_idle              = 1'b1;
    start                  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();
    if (restart && ways > 0) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while ((exp_word.size() != 0 || done_cnt == d0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check_value("words_left", 64'(exp_word.size()), 64'd0);
    check_value("reqs_left", 64'(exp_req.size()), 64'd0);
    check_value("done_pulses", 64'(done_cnt - d0), 64'd1);
    exp_word.delete();
    exp_req.delete();
    rdy_rand = 1'b0;
  endtask

  initial begin
    int target, n;
    for (int i = 0; i < 256; i++) wmem[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 8; k++) bmem[i][k*32 +: 32] = $urandom;
    start = 1'b0; abort = 1'b0; core_idle = 1'b1;
    ways_received = 8'd0; embedding_layer_blocks = 4'd0;
    max_weight_address = 8'd0; max_bias_address = 4'd0; use_subsection = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_wen", 64'(bus_if.weight_mem_en), 64'd0);
    check_value("rst_waddr", 64'(bus_if.weight_mem_addr), 64'd0);
    check_value("rst_ben", 64'(bus_if.bias_mem_en), 64'd0);
    check_value("rst_baddr", 64'(bus_if.bias_mem_addr), 64'd0);
    check_value("rst_valid", 64'(bus_if.out_valid), 64'd0);
    check_value("rst_data", 64'(bus_if.out_data), 64'd0);
    check_value("rst_is_bias", 64'(bus_if.out_is_bias), 64'd0);
    check_value("rst_way", 64'(bus_if.out_way), 64'd0);
    check_value("rst_last", 64'(bus_if.out_last), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic readout with a negative weight in lane 0 of the first row.
    wmem[8][3:0] = 4'hF;
    first_cap = 1'b1;
    do_readout(3, 1, 8, 2, 1'b0, 1'b0, 1'b0);
    check_value("sext_weight", 64'(first_data), 64'hFFFF);

    // Multi-group readouts in normal and subsection lane mapping.
    do_readout(18, 0, 40, 5, 1'b0, 1'b1, 1'b0);
    do_readout(18, 0, 40, 5, 1'b1, 1'b1, 1'b0);

    // Zero ways: done only; then start while core busy elsewhere.
    do_readout(0, 2, 3, 3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    core_idle = 1'b0; ways_received = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; core_idle = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_value("core_busy_ignored", 64'(busy), 64'd0);

    // Abort while waiting for the first row of way 2.
    build_expect(4, 1, 20, 7, 1'b0);
    target = issued_cnt + 7;
    @(posedge clk); #1;
    ways_received = 8'd4; embedding_layer_blocks = 4'd1;
    max_weight_address = 8'd20; max_bias_address = 4'd7; use_subsection = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (issued_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_value("abort_reached_way2", 64'(issued_cnt), 64'(target));
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_word.delete();
    exp_req.delete();
    @(negedge clk);
    check_value("abort_busy", 64'(busy), 64'd0);
    check_value("abort_valid", 64'(bus_if.out_valid), 64'd0);
    check_value("abort_wen", 64'(bus_if.weight_mem_en), 64'd0);
    check_value("abort_last", 64'(bus_if.out_last), 64'd0);
    repeat (4) @(posedge clk);
    do_readout(4, 1, 20, 7, 1'b0, 1'b0, 1'b0);

    // Randomized configurations with backpressure and a start while busy.
    for (int it = 0; it < 6; it++) begin
      do_readout($urandom_range(1, 24), $urandom_range(0, 4), $urandom_range(0, 255),
                 $urandom_range(0, 15), 1'($urandom), 1'b1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
